// File: rtl/alu_arb_pkg.sv
// Shared types for the two-client ALU front end: FSM states and opcodes.
// OP_LAST is the highest opcode the ALU implements.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_ROL  = 4'd10;
  localparam logic [3:0] OP_ROR  = 4'd11;
  localparam logic [3:0] OP_EQ   = 4'd12;
  localparam logic [3:0] OP_LAST = 4'd12;

endpackage

// File: rtl/alu_arbiter_rr.sv
// alu_rr_arb: combinational 2-way round-robin picker.
// Ports: req_valid[1:0], last_grant (client served last) -> gnt one-hot.
module alu_rr_arb
  import alu_arb_pkg::*;
(
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  // On a tie the client not served last wins.
  assign gnt[0] = req_valid[0] &
                  (~req_valid[1] | last_grant);
  assign gnt[1] = req_valid[1] &
                  (~req_valid[0] | ~last_grant);

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-client round-robin front end for a shared external ALU.
// Ports: clk, reset (sync, active-high); req_valid/req_ready/req_ctrl/
// req_x/req_y per client; rsp_valid/rsp_ready per client with shared
// rsp_out/rsp_carry/rsp_err; alu_ctrl/alu_x/alu_y drive to the ALU,
// alu_out/alu_carry back from it; op_cnt counts completed responses.
// Optional: define ALU_ARB_OPCHK_EN to reject opcodes above OP_LAST.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [7:0]   req_ctrl,
  input  logic [2*W-1:0] req_x,
  input  logic [2*W-1:0] req_y,
  output logic [1:0]   rsp_valid,
  input  logic [1:0]   rsp_ready,
  output logic [W-1:0] rsp_out,
  output logic         rsp_carry,
  output logic         rsp_err,
  output logic [3:0]   alu_ctrl,
  output logic [W-1:0] alu_x,
  output logic [W-1:0] alu_y,
  input  logic [W-1:0] alu_out,
  input  logic         alu_carry,
  output logic [15:0]  op_cnt
);

  state_t         state;
  state_t         state_nxt;
  logic           last_grant;
  logic           gnt;
  logic [1:0]     gnt_oh;
  logic           sel;
  logic           accept;
  logic           rsp_hs;
  logic           illegal;
  logic [3:0]     sel_ctrl;
  logic [W-1:0]   sel_x;
  logic [W-1:0]   sel_y;

  alu_rr_arb u_arb (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .gnt        (gnt_oh)
  );

  assign req_ready = (state == IDLE) ? gnt_oh : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign sel       = gnt_oh[1];

  assign sel_ctrl = sel ? req_ctrl[7:4] : req_ctrl[3:0];
  assign sel_x    = sel ? req_x[2*W-1:W] : req_x[W-1:0];
  assign sel_y    = sel ? req_y[2*W-1:W] : req_y[W-1:0];

`ifdef ALU_ARB_OPCHK_EN
  assign illegal = sel_ctrl > OP_LAST;
`else
  assign illegal = 1'b0;
`endif

  assign rsp_valid = (state != RESP) ? 2'b00 :
                     (gnt ? 2'b10 : 2'b01);
  assign rsp_hs    = (state == RESP) & rsp_ready[gnt];

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = illegal ? RESP : EXEC;
      EXEC: state_nxt = RESP;
      RESP: if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      alu_ctrl   <= '0;
      alu_x      <= '0;
      alu_y      <= '0;
      rsp_out    <= '0;
      rsp_carry  <= 1'b0;
      op_cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        last_grant <= sel;
        gnt        <= sel;
        // Rejected opcodes leave the ALU drive untouched.
        if (illegal) begin
          rsp_out   <= '0;
          rsp_carry <= 1'b0;
        end else begin
          alu_ctrl <= sel_ctrl;
          alu_x    <= sel_x;
          alu_y    <= sel_y;
        end
      end
      if (state == EXEC) begin
        rsp_out   <= alu_out;
        rsp_carry <= alu_carry;
      end
      if (rsp_hs) op_cnt <= op_cnt + 16'd1;
    end
  end

`ifdef ALU_ARB_OPCHK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= illegal;
    end
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic checked
// against a transaction-level model; also plays the external ALU.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_ctrl;
  logic [15:0] req_x;
  logic [15:0] req_y;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [7:0]  rsp_out;
  logic        rsp_carry;
  logic        rsp_err;
  logic [3:0]  alu_ctrl;
  logic [7:0]  alu_x;
  logic [7:0]  alu_y;
  logic [7:0]  alu_out;
  logic        alu_carry;
  logic [15:0] op_cnt;

  int errors = 0;
  int checks = 0;

`ifdef ALU_ARB_OPCHK_EN
  localparam bit OPCHK = 1'b1;
`else
  localparam bit OPCHK = 1'b0;
`endif

  // Model state: who was served last, responses completed, last ALU drive.
  int         m_last;
  int         m_cnt;
  logic [3:0] m_ctrl;
  logic [7:0] m_x;
  logic [7:0] m_y;

  always #5 clk = ~clk;

  function automatic logic [8:0] ref_alu(input logic [3:0] c,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
    logic [7:0] s;
    s = $signed(a) >>> 1;
    case (c)
      4'd0:  return {1'b0, a} + {1'b0, b};
      4'd1:  return {1'b0, a} - {1'b0, b};
      4'd2:  return {1'b0, a & b};
      4'd3:  return {1'b0, a | b};
      4'd4:  return {1'b0, ~a};
      4'd5:  return {1'b0, a ^ b};
      4'd6:  return {1'b0, ~(a | b)};
      4'd7:  return {a[7], a[6:0], 1'b0};
      4'd8:  return {a[0], 1'b0, a[7:1]};
      4'd9:  return {a[0], s};
      4'd10: return {1'b0, a[6:0], a[7]};
      4'd11: return {1'b0, a[0], a[7:1]};
      4'd12: return {8'd0, a == b};
      default: return 9'd0;
    endcase
  endfunction

  assign {alu_carry, alu_out} = ref_alu(alu_ctrl, alu_x, alu_y);

  alu_arbiter #(.W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_ctrl  (req_ctrl),
    .req_x     (req_x),
    .req_y     (req_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_out   (rsp_out),
    .rsp_carry (rsp_carry),
    .rsp_err   (rsp_err),
    .alu_ctrl  (alu_ctrl),
    .alu_x     (alu_x),
    .alu_y     (alu_y),
    .alu_out   (alu_out),
    .alu_carry (alu_carry),
    .op_cnt    (op_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_last = 1;
    m_cnt  = 0;
    m_ctrl = 4'd0;
    m_x    = 8'd0;
    m_y    = 8'd0;
  endtask

  // One full transaction from request to response handshake, with bp
  // cycles of response backpressure (the other client's rsp_ready set).
  task automatic run_txn(input logic [1:0] v,
                         input logic [3:0] c0, input logic [7:0] x0,
                         input logic [7:0] y0,
                         input logic [3:0] c1, input logic [7:0] x1,
                         input logic [7:0] y1, input int bp);
    int         g;
    logic [3:0] c;
    logic [7:0] x;
    logic [7:0] y;
    logic [8:0] r;
    logic       bad;
    req_valid = v;
    req_ctrl  = {c1, c0};
    req_x     = {x1, x0};
    req_y     = {y1, y0};
    rsp_ready = 2'b00;
    #1;
    if (v == 2'b11) g = (m_last == 1) ? 0 : 1;
    else            g = v[1] ? 1 : 0;
    c = g ? c1 : c0;
    x = g ? x1 : x0;
    y = g ? y1 : y0;
    bad = OPCHK && (c > 4'd12);
    chk("req_ready_idle", req_ready, 32'd1 << g);
    step();
    m_last = g;
    req_valid = 2'b00;
    if (bad) begin
      r = 9'd0;
      chk("alu_ctrl_kept", alu_ctrl, m_ctrl);
      chk("alu_x_kept", alu_x, m_x);
    end else begin
      m_ctrl = c;
      m_x    = x;
      m_y    = y;
      r = ref_alu(c, x, y);
      chk("exec_rsp_valid", rsp_valid, 0);
      chk("exec_req_ready", req_ready, 0);
      chk("alu_ctrl", alu_ctrl, c);
      chk("alu_x", alu_x, x);
      chk("alu_y", alu_y, y);
      step();
    end
    for (int i = 0; i <= bp; i++) begin
      chk("rsp_valid", rsp_valid, 32'd1 << g);
      chk("rsp_out", rsp_out, r[7:0]);
      chk("rsp_carry", rsp_carry, r[8]);
      chk("rsp_err", rsp_err, bad);
      chk("resp_req_ready", req_ready, 0);
      chk("op_cnt_hold", op_cnt, m_cnt);
      if (i < bp) begin
        rsp_ready = 2'b01 << (1 - g);
        req_valid = v;
        step();
      end
    end
    req_valid = 2'b00;
    rsp_ready = 2'b01 << g;
    step();
    m_cnt = (m_cnt + 1) % 65536;
    rsp_ready = 2'b00;
    chk("op_cnt_inc", op_cnt, m_cnt);
    chk("idle_rsp_valid", rsp_valid, 0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 2'b00;
    req_ctrl  = 8'd0;
    req_x     = 16'd0;
    req_y     = 16'd0;
    rsp_ready = 2'b00;
    model_reset();
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_out", rsp_out, 0);
    chk("rst_rsp_carry", rsp_carry, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    chk("rst_alu_x", alu_x, 0);
    chk("rst_alu_y", alu_y, 0);
    chk("rst_op_cnt", op_cnt, 0);

    // Single ADD then SUB underflow.
    run_txn(2'b01, 4'd0, 8'h7F, 8'h01, 4'd0, 8'h00, 8'h00, 0);
    chk("add_cnt", op_cnt, 1);
    run_txn(2'b10, 4'd0, 8'h00, 8'h00, 4'd1, 8'h00, 8'h01, 0);

    // Ties right after reset: client 0 first, then client 1.
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    run_txn(2'b11, 4'd0, 8'h03, 8'h04, 4'd2, 8'hF0, 8'h3C, 0);
    chk("tie1_result", ref_alu(4'd0, 8'h03, 8'h04), 9'h007);
    run_txn(2'b11, 4'd0, 8'h03, 8'h04, 4'd2, 8'hF0, 8'h3C, 0);
    run_txn(2'b11, 4'd0, 8'h10, 8'h20, 4'd2, 8'hF0, 8'h3C, 0);

    // Five cycles of response backpressure.
    run_txn(2'b01, 4'd5, 8'hA5, 8'h0F, 4'd0, 8'h00, 8'h00, 5);

    // Opcode beyond the ALU's range.
    run_txn(2'b01, 4'd14, 8'h12, 8'h34, 4'd0, 8'h00, 8'h00, 0);

    // Reset while in EXEC drops the operation.
    req_valid = 2'b01;
    req_ctrl  = {4'd0, 4'd0};
    req_x     = {8'h00, 8'h11};
    req_y     = {8'h00, 8'h22};
    #1;
    step();
    req_valid = 2'b00;
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    chk("rstexec_rsp_valid", rsp_valid, 0);
    chk("rstexec_op_cnt", op_cnt, 0);
    chk("rstexec_alu_ctrl", alu_ctrl, 0);
    run_txn(2'b10, 4'd0, 8'h00, 8'h00, 4'd7, 8'h81, 8'h00, 0);

    // Random traffic.
    for (int n = 0; n < 60; n++) begin
      run_txn(2'($urandom_range(1, 3)),
              4'($urandom_range(0, 15)), 8'($urandom),
              8'($urandom),
              4'($urandom_range(0, 15)), 8'($urandom),
              8'($urandom),
              int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester front end for the shared 8-bit ALU. Accepts operations (4-bit opcode plus two 8-bit operands) from two independent clients over valid/ready handshakes and arbitrates round-robin. It drives the combinational ALU from registered operands, captures its result, and returns it to the granted client over a held response handshake. It sits between the client blocks and the single ALU instance, which is external to this block.

## Interface
Parameters:
- `W`, 8: operand/result width. The ALU carry is bit W of its 9-bit internal result.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 2: bit i is the request from client i.
- `req_ready` out 2: bit i is the accept to client i.
- `req_ctrl` in 8: client i opcode at [4i+3:4i].
- `req_x`, `req_y` in 2W: client i operands at [Wi+W-1:Wi].
- `rsp_valid` out 2: bit i means the response is for client i. At most one bit is set.
- `rsp_ready` in 2: client i accepts its response.
- `rsp_out` out W: shared result bus.
- `rsp_carry` out 1: shared carry.
- `rsp_err` out 1: illegal opcode flag (see Configuration).
- `alu_ctrl` out 4, `alu_x` out W, `alu_y` out W: registered drive to the ALU.
- `alu_out` in W, `alu_carry` in 1: combinational ALU result.
- `op_cnt` out 16: count of completed responses.

## Operation
- FSM states:
  - IDLE → EXEC on a request handshake.
  - EXEC → RESP unconditionally.
  - RESP → IDLE on the response handshake (rsp_valid[g] & rsp_ready[g]).
- Arbitration in IDLE only:
  - Grant g is the requester with valid set. If both are valid, grant the one not granted last.
  - `last_grant` resets to 1, so client 0 wins the first tie. It updates to g on each accept.
- `req_ready[g]` = 1 only in IDLE, and only for the granted g. Both bits are 0 in EXEC and RESP.
- On accept, latch opcode, x, y and g into `alu_ctrl`, `alu_x`, `alu_y` and `gnt`.
- In EXEC, the ALU evaluates the latched operands. At the EXEC→RESP edge, register `alu_out` and `alu_carry` into `rsp_out` and `rsp_carry`.
- In RESP:
  - `rsp_valid[gnt]` = 1.
  - `rsp_out`, `rsp_carry` and `rsp_err` are held stable until the handshake.
- `op_cnt` increments on each response handshake and wraps from 0xFFFF to 0.
- Clients must hold valid and payload stable until ready. The arbiter samples the payload only at handshake.
- The ALU drive registers hold their last value outside EXEC. They are not cleared between operations.
- Reset in any state drops the in-flight operation. No response is produced and the state returns to IDLE.

## Timing
- Reset values:
  - state = IDLE.
  - All outputs 0: `req_ready`, `rsp_valid`, `rsp_out`, `rsp_carry`, `rsp_err`, `alu_ctrl`, `alu_x`, `alu_y`, `op_cnt`.
  - `last_grant` = 1.
- Latency and throughput:
  - Accept in cycle N; `alu_*` valid in N+1; `rsp_valid` high in N+2.
  - With `rsp_ready` held high, the next accept is possible in N+3, giving a peak throughput of 1 operation per 3 cycles.
- `req_ready` is a combinational function of state, `req_valid` and `last_grant`. All other outputs are registered.
- Backpressure: `rsp_ready` low holds RESP indefinitely, and both `req_ready` bits stay 0.
- The non-granted client's `rsp_ready` is ignored.

## Configuration
- `ALU_ARB_OPCHK_EN` defined:
  - Opcodes 13–15 are accepted but not issued to the ALU. The FSM goes IDLE→RESP directly, and `alu_*` are unchanged.
  - The response is `rsp_out` = 0, `rsp_carry` = 0, `rsp_err` = 1, returned in N+1.
  - Legal opcodes respond with `rsp_err` = 0.
- Undefined: all opcodes are forwarded to the ALU with the normal latency, and `rsp_err` is tied 0.

## Structure
- Package `alu_arb_pkg` holds:
  - The FSM state enum (IDLE, EXEC, RESP).
  - Opcode localparams: OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_NOT=4, OP_XOR=5, OP_NOR=6, OP_SHL=7, OP_SHR=8, OP_SRA=9, OP_ROL=10, OP_ROR=11, OP_EQ=12, OP_LAST=12.
- Sub-module `alu_rr_arb`: a 2-way round-robin picker taking `req_valid` and `last_grant` and producing the grant one-hot. It is purely combinational.

## Test plan
- Single ADD: client 0 sends ctrl=0, x=0x7F, y=0x01 in cycle N → `alu_ctrl`=0 in N+1; `rsp_valid`=2'b01, `rsp_out`=0x80, `rsp_carry`=0 in N+2; `op_cnt`=1.
- SUB underflow: client 1 sends ctrl=1, x=0x00, y=0x01 → `rsp_valid`=2'b10, `rsp_out`=0xFF, `rsp_carry`=1.
- Tie: both clients valid after reset, with client 0 sending ADD 0x03+0x04 and client 1 sending AND 0xF0&0x3C → client 0 is served first (0x07), then client 1 (0x30). A second tie grants client 1 first.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid` and `rsp_out` are stable, `req_ready`=0 throughout, and `op_cnt` is unchanged until the handshake.
- Illegal opcode with `ALU_ARB_OPCHK_EN`: ctrl=14 → response in N+1 with `rsp_err`=1, `rsp_out`=0, and `alu_ctrl` unchanged. Without the macro: `alu_ctrl`=14 and `rsp_err`=0.
- Reset in EXEC: assert `reset` for 1 cycle → no `rsp_valid`, `op_cnt`=0, and a new request is accepted in the cycle after reset is released.
